// File: rtl/duty_ctrl_if.sv
// Button-command and duty-output bundle for duty_ctrl; all fields are plain levels or one-cycle pulses.
// No handshake: commands are sampled every clk edge and outputs are always valid.
interface duty_ctrl_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
);
    logic [CHANNELS-1:0]       inc;
    logic [CHANNELS-1:0]       dec;
    logic [CHANNELS-1:0]       preset;
    logic                      estop;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS*WIDTH-1:0] target;
    logic [CHANNELS-1:0]       settled;

    modport master (
        output inc, dec, preset, estop,
        input  duty, target, settled
    );

    modport slave (
        input  inc, dec, preset, estop,
        output duty, target, settled
    );
endinterface

// File: rtl/duty_ctrl.sv
// Per-channel saturating target with slew-limited duty ramp; target follows commands after 1 edge,
// duty moves only on prescaler ticks (estop zeroes both at once); no backpressure, inputs always accepted.
module duty_ctrl #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int STEP      = 8,
    parameter int PRESET    = 128,
    parameter int RAMP_DIV  = 250000,
    parameter int RAMP_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    duty_ctrl_if.slave  io
);
    localparam int              CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0]   DIV_LAST = CW'(RAMP_DIV - 1);
    localparam longint          FULL     = (longint'(1) << WIDTH) - 1;
    localparam logic [WIDTH:0]  MAX_W    = {1'b0, {WIDTH{1'b1}}};
    // Steps wider than the duty word behave exactly like a full-scale step, so clamp them.
    localparam logic [WIDTH:0]  STEP_W   = (STEP >= FULL) ? MAX_W : (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] RSTEP_W = (RAMP_STEP >= FULL) ? {WIDTH{1'b1}} : WIDTH'(RAMP_STEP);
    localparam logic [WIDTH-1:0] PRESET_W = WIDTH'(PRESET);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    always_comb begin
        tick  = (cnt_q == DIV_LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] target_q, target_d;
        logic [WIDTH-1:0] duty_q, duty_d;
        logic [WIDTH-1:0] gap, ramp_amt;
        logic [WIDTH:0]   up_sum;

        always_comb begin
            up_sum   = {1'b0, target_q} + STEP_W;
            target_d = target_q;
            if (io.estop)
                target_d = '0;
            else if (io.preset[g])
                target_d = PRESET_W;
            else if (io.inc[g] && !io.dec[g])
                target_d = (up_sum > MAX_W) ? MAX_W[WIDTH-1:0] : up_sum[WIDTH-1:0];
            else if (io.dec[g] && !io.inc[g])
                target_d = ({1'b0, target_q} >= STEP_W) ? target_q - STEP_W[WIDTH-1:0] : '0;

            // Ramp toward the pre-edge target; clipping to the gap prevents overshoot.
            gap      = (duty_q < target_q) ? target_q - duty_q : duty_q - target_q;
            ramp_amt = (gap < RSTEP_W) ? gap : RSTEP_W;
            duty_d   = duty_q;
            if (io.estop)
                duty_d = '0;
            else if (tick && (duty_q < target_q))
                duty_d = duty_q + ramp_amt;
            else if (tick && (duty_q > target_q))
                duty_d = duty_q - ramp_amt;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                target_q <= PRESET_W;
                duty_q   <= '0;
            end else begin
                target_q <= target_d;
                duty_q   <= duty_d;
            end
        end

        assign io.duty[g*WIDTH +: WIDTH]   = duty_q;
        assign io.target[g*WIDTH +: WIDTH] = target_q;
        assign io.settled[g]               = (duty_q == target_q);
    end
endmodule
